// File: rtl/pc_branch_unit_if.sv
// Bundle of the PC/branch unit's datapath and handshake signals.
// master = control/datapath side, slave = pc_branch_unit.
interface pc_branch_unit_if;
    logic [15:0] BUS;
    logic [15:0] IR;
    logic [15:0] BASER;
    logic        LD_PC;
    logic [1:0]  PCMUX;
    logic        ADDR1MUX;
    logic [1:0]  ADDR2MUX;
    logic        BR_REQ;
    logic        BEN;
    logic        LD_BEN;
    logic        BR_BUSY;
    logic        BR_DONE;
    logic        BR_TAKEN;
    logic [15:0] PC;
    logic [15:0] ADDR_OUT;

    modport master (
        output BUS, IR, BASER, LD_PC, PCMUX, ADDR1MUX, ADDR2MUX, BR_REQ, BEN,
        input  LD_BEN, BR_BUSY, BR_DONE, BR_TAKEN, PC, ADDR_OUT
    );

    modport slave (
        input  BUS, IR, BASER, LD_PC, PCMUX, ADDR1MUX, ADDR2MUX, BR_REQ, BEN,
        output LD_BEN, BR_BUSY, BR_DONE, BR_TAKEN, PC, ADDR_OUT
    );
endinterface

// File: rtl/pc_branch_unit.sv
// LC-3 program counter, MARMUX address adder and PCMUX, plus the
// LATCH/EVAL/DONE sequence that resolves a conditional branch via BR_COMP.
module pc_branch_unit #(
    parameter logic [15:0] RESET_PC = 16'h3000
) (
    input logic              CLK,
    input logic              RESET,
    pc_branch_unit_if.slave  br
);
    typedef enum logic [1:0] {IDLE, LATCH, EVAL, DONE} state_t;

    state_t      state;
    logic [15:0] pc;
    logic        taken;

    logic [15:0] addr1;
    logic [15:0] addr2;
    logic [15:0] addr_sum;
    logic [15:0] pc_next_ext;
    logic [15:0] off9;

    assign off9 = {{7{br.IR[8]}}, br.IR[8:0]};

    always_comb begin
        addr1 = br.ADDR1MUX ? br.BASER : pc;
        case (br.ADDR2MUX)
            2'b00:   addr2 = '0;
            2'b01:   addr2 = {{10{br.IR[5]}}, br.IR[5:0]};
            2'b10:   addr2 = off9;
            default: addr2 = {{5{br.IR[10]}}, br.IR[10:0]};
        endcase
        addr_sum = addr1 + addr2;
    end

    always_comb begin
        case (br.PCMUX)
            2'b00:   pc_next_ext = pc + 16'd1;
            2'b01:   pc_next_ext = br.BUS;
            2'b10:   pc_next_ext = addr_sum;
            default: pc_next_ext = pc;
        endcase
    end

    // Loads in IDLE coexist with BR_REQ, so EVAL adds the offset to the freshly loaded PC.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            pc    <= RESET_PC;
            taken <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (br.LD_PC)
                        pc <= pc_next_ext;
                    if (br.BR_REQ)
                        state <= LATCH;
                end
                LATCH: state <= EVAL;
                EVAL: begin
                    if (br.BEN)
                        pc <= pc + off9;
                    taken <= br.BEN;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign br.LD_BEN   = (state == LATCH);
    assign br.BR_BUSY  = (state != IDLE);
    assign br.BR_DONE  = (state == DONE);
    assign br.BR_TAKEN = taken;
    assign br.PC       = pc;
    assign br.ADDR_OUT = addr_sum;
endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: directed scenarios plus random traffic, all
// checked every cycle against a cycle-count based reference model.
module tb_pc_branch_unit;
    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    pc_branch_unit_if bif ();
    pc_branch_unit #(.RESET_PC(16'h3000)) dut (.CLK(CLK), .RESET(RESET), .br(bif));

    int total = 0;
    int bad   = 0;

    // model: PC, taken flag, and edge index at which the current request was accepted
    logic [15:0] m_pc;
    logic        m_taken;
    int          cyc     = 0;
    int          req_cyc = -100;
    int          dones;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] sext(input logic [15:0] v, input int bits);
        int x;
        x = int'(v) & ((1 << bits) - 1);
        if (x >= (1 << (bits - 1)))
            x = x - (1 << bits);
        return 16'(x);
    endfunction

    function automatic logic [15:0] exp_addr();
        int base, off;
        base = bif.ADDR1MUX ? int'(bif.BASER) : int'(m_pc);
        case (bif.ADDR2MUX)
            2'd0:    off = 0;
            2'd1:    off = int'(sext(bif.IR, 6));
            2'd2:    off = int'(sext(bif.IR, 9));
            default: off = int'(sext(bif.IR, 11));
        endcase
        return 16'((base + off) % 65536);
    endfunction

    // one clock: update the model from inputs seen at the edge, then check all outputs
    task automatic tick();
        int e;
        logic [15:0] sel;
        @(posedge CLK);
        e = cyc - req_cyc;
        if (RESET) begin
            m_pc    = 16'h3000;
            m_taken = 1'b0;
            req_cyc = -100;
        end else if (e >= 4) begin
            case (bif.PCMUX)
                2'd0:    sel = 16'((int'(m_pc) + 1) % 65536);
                2'd1:    sel = bif.BUS;
                2'd2:    sel = exp_addr();
                default: sel = m_pc;
            endcase
            if (bif.LD_PC)
                m_pc = sel;
            if (bif.BR_REQ)
                req_cyc = cyc;
        end else if (e == 2) begin
            if (bif.BEN)
                m_pc = 16'((int'(m_pc) + int'(sext(bif.IR, 9))) % 65536);
            m_taken = bif.BEN;
        end
        cyc++;
        #1;
        e = cyc - req_cyc;
        chk("pc",      bif.PC,               m_pc);
        chk("addr",    bif.ADDR_OUT,         exp_addr());
        chk("busy",    16'(bif.BR_BUSY),     16'(e >= 1 && e <= 3));
        chk("ld_ben",  16'(bif.LD_BEN),      16'(e == 1));
        chk("br_done", 16'(bif.BR_DONE),     16'(e == 3));
        chk("taken",   16'(bif.BR_TAKEN),    16'(m_taken));
        if (bif.BR_DONE) dones++;
    endtask

    task automatic load_pc(input logic [15:0] v);
        bif.LD_PC = 1'b1; bif.PCMUX = 2'b01; bif.BUS = v;
        tick();
        bif.LD_PC = 1'b0; bif.PCMUX = 2'b11;
    endtask

    initial begin
        RESET = 1'b1;
        bif.BUS = '0; bif.IR = '0; bif.BASER = '0; bif.LD_PC = 1'b0;
        bif.PCMUX = 2'b00; bif.ADDR1MUX = 1'b0; bif.ADDR2MUX = 2'b00;
        bif.BR_REQ = 1'b0; bif.BEN = 1'b0;
        m_pc = '0; m_taken = 1'b0; dones = 0;

        // reset
        tick();
        RESET = 1'b0;
        chk("rst_pc", bif.PC, 16'h3000);
        chk("rst_busy", 16'(bif.BR_BUSY), 16'd0);

        // increment three times, then hold
        bif.LD_PC = 1'b1; bif.PCMUX = 2'b00;
        repeat (3) tick();
        chk("inc_pc", bif.PC, 16'h3003);
        bif.PCMUX = 2'b11;
        tick();
        chk("hold_pc", bif.PC, 16'h3003);
        bif.LD_PC = 1'b0;

        // taken branch
        load_pc(16'h3001);
        bif.IR = 16'h0E05; bif.BR_REQ = 1'b1;
        tick();
        bif.BR_REQ = 1'b0;
        chk("t_ldben", 16'(bif.LD_BEN), 16'd1);
        bif.BEN = 1'b1;
        tick(); tick();
        chk("t_pc", bif.PC, 16'h3006);
        chk("t_done", 16'(bif.BR_DONE), 16'd1);
        chk("t_taken", 16'(bif.BR_TAKEN), 16'd1);
        tick();

        // not taken, then taken with wrap to 0xFFFF
        for (int b = 0; b < 2; b++) begin
            load_pc(16'h0000);
            bif.IR = 16'h01FF; bif.BEN = b[0]; bif.BR_REQ = 1'b1;
            tick();
            bif.BR_REQ = 1'b0;
            tick(); tick(); tick();
            chk("wrap_pc", bif.PC, b ? 16'hFFFF : 16'h0000);
            chk("wrap_taken", 16'(bif.BR_TAKEN), 16'(b));
        end

        // requests and loads while busy are ignored
        bif.BEN = 1'b0; bif.BR_REQ = 1'b1;
        tick();
        dones = 0;
        bif.LD_PC = 1'b1; bif.PCMUX = 2'b01; bif.BUS = 16'h1234;
        tick();
        bif.LD_PC = 1'b0; bif.BR_REQ = 1'b0;
        repeat (5) tick();
        chk("busy_pc", bif.PC, 16'hFFFF);
        chk("busy_dones", 16'(dones), 16'd1);

        // reset during EVAL abandons the branch
        bif.BR_REQ = 1'b1;
        tick();
        bif.BR_REQ = 1'b0;
        tick();
        bif.BEN = 1'b1; RESET = 1'b1;
        dones = 0;
        tick();
        RESET = 1'b0;
        repeat (3) tick();
        chk("midrst_pc", bif.PC, 16'h3000);
        chk("midrst_dones", 16'(dones), 16'd0);
        chk("midrst_taken", 16'(bif.BR_TAKEN), 16'd0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            RESET        = ($urandom_range(0, 49) == 0);
            bif.BUS      = 16'($urandom);
            bif.IR       = 16'($urandom);
            bif.BASER    = 16'($urandom);
            bif.LD_PC    = 1'($urandom);
            bif.PCMUX    = 2'($urandom);
            bif.ADDR1MUX = 1'($urandom);
            bif.ADDR2MUX = 2'($urandom);
            bif.BR_REQ   = ($urandom_range(0, 2) == 0);
            bif.BEN      = 1'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
